// File: rtl/perf_monitor_pkg.sv
// Shared types and helpers for the perf monitor.
// Used by perf_monitor and perf_bcd_conv.
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perf_state_t;

  typedef enum logic [1:0] {
    BCD_LOAD,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_t;

  localparam int SEL_TOTAL = 0;

  // Decimal digits needed for a width-bit binary value.
  function automatic int bcd_digits(input int width);
    return (width * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/perf_bcd_conv.sv
// Sequential double-dabble converter, one bit per cycle.
// Restarts whenever the binary input changes.
module perf_bcd_conv
  import perf_monitor_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int DIG   = bcd_digits(WIDTH),
  localparam int BW    = 4 * DIG,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] bin_i,
  output logic [BW-1:0]    bcd_o,
  output logic             valid_o
);

  bcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             valid_q, valid_d;

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIG; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    unique case (state_q)
      BCD_LOAD: begin
        sh_d    = last_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = BCD_SHIFT;
      end
      BCD_SHIFT: begin
        {acc_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = acc_d;
          valid_d = 1'b1;
          state_d = BCD_DONE;
        end
      end
      BCD_DONE: ;
      default: state_d = BCD_LOAD;
    endcase
    if (bin_i != last_q) begin
      state_d = BCD_LOAD;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BCD_LOAD;
      last_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= bin_i;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/perf_monitor.sv
// Cycle and PC-window performance counters with completion detect.
// PERF_MONITOR_BCD_EN adds a BCD readout of the selected counter.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter  int PC_WIDTH     = 10,
  parameter  int COUNT_WIDTH  = 32,
  parameter  int NUM_CHANNELS = 4,
  parameter  int FINAL_PC     = 2**PC_WIDTH - 1,
  parameter  int FINISH_HOLD  = 2,
  localparam int SEL_W        = $clog2(NUM_CHANNELS + 1),
  localparam int WIN_W        = NUM_CHANNELS * PC_WIDTH,
  localparam int BCD_W        = 4 * bcd_digits(COUNT_WIDTH)
) (
  input  logic                   CLK_50,
  input  logic                   resetN,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   pc_valid,
  input  logic                   clear,
  input  logic [WIN_W-1:0]       ch_lo,
  input  logic [WIN_W-1:0]       ch_hi,
  input  logic [SEL_W-1:0]       sel,
  output logic [COUNT_WIDTH-1:0] sel_count,
  output logic                   sel_ovf,
  output logic                   running,
  output logic                   finished
`ifdef PERF_MONITOR_BCD_EN
  ,
  output logic [BCD_W-1:0]       sel_bcd,
  output logic                   bcd_valid
`endif
);

  localparam int HOLD_W = $clog2(FINISH_HOLD + 1);
  localparam logic [PC_WIDTH-1:0] FINAL_V = PC_WIDTH'(FINAL_PC);

  perf_state_t            state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   count_en;
  logic [COUNT_WIDTH-1:0] total_q;
  logic                   total_ovf_q;
  logic [COUNT_WIDTH-1:0] ch_cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_ovf;
  logic [COUNT_WIDTH-1:0] sel_count_q, sel_count_d;
  logic                   sel_ovf_q, sel_ovf_d;

  // The IDLE->RUN cycle is itself counted.
  assign count_en = !clear &&
    (state_q == RUN || (state_q == IDLE && pc_valid));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (clear) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (pc_valid) state_d = RUN;
        RUN: begin
          if (pc_valid && pc == FINAL_V) begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(FINISH_HOLD - 1)) state_d = DONE;
          end else if (pc_valid) begin
            hold_d = '0;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      total_q     <= '0;
      total_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (clear) begin
        total_q     <= '0;
        total_ovf_q <= 1'b0;
      end else if (count_en) begin
        if (&total_q) total_ovf_q <= 1'b1;
        else          total_q     <= total_q + COUNT_WIDTH'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [PC_WIDTH-1:0]    lo, hi;
    logic                   hit;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   ovf_q;

    // An inverted window (lo > hi) can never satisfy both bounds.
    assign lo  = ch_lo[k*PC_WIDTH +: PC_WIDTH];
    assign hi  = ch_hi[k*PC_WIDTH +: PC_WIDTH];
    assign hit = pc_valid && pc >= lo && pc <= hi;

    always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (count_en && hit) begin
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
    end

    assign ch_cnt[k] = cnt_q;
    assign ch_ovf[k] = ovf_q;
  end

  always_comb begin
    sel_count_d = '0;
    sel_ovf_d   = 1'b0;
    if (sel == SEL_W'(SEL_TOTAL)) begin
      sel_count_d = total_q;
      sel_ovf_d   = total_ovf_q;
    end
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        sel_count_d = ch_cnt[k];
        sel_ovf_d   = ch_ovf[k];
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      sel_count_q <= '0;
      sel_ovf_q   <= 1'b0;
    end else begin
      sel_count_q <= sel_count_d;
      sel_ovf_q   <= sel_ovf_d;
    end
  end

  assign sel_count = sel_count_q;
  assign sel_ovf   = sel_ovf_q;
  assign running   = (state_q == RUN);
  assign finished  = (state_q == DONE);

`ifdef PERF_MONITOR_BCD_EN
  perf_bcd_conv #(
    .WIDTH(COUNT_WIDTH)
  ) u_bcd (
    .clk_i  (CLK_50),
    .rst_ni (resetN),
    .bin_i  (sel_count_q),
    .bcd_o  (sel_bcd),
    .valid_o(bcd_valid)
  );
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// Directed scoreboard bench for perf_monitor.
// Second instance uses 4-bit counters for saturation.
module tb_perf_monitor;
  import perf_monitor_pkg::*;

  localparam int PCW  = 10;
  localparam int NCH  = 4;
  localparam int SELW = 3;
  localparam logic [PCW-1:0] FIN = 10'd1023;

  logic clk = 1'b0;
  logic rst_n;
  logic [PCW-1:0] pc;
  logic pc_valid, clear;
  logic [NCH*PCW-1:0] ch_lo, ch_hi;
  logic [SELW-1:0] sel;

  logic [31:0] cnt_m;
  logic ovf_m, run_m, fin_m;
  logic [3:0] cnt_s;
  logic ovf_s, run_s, fin_s;
`ifdef PERF_MONITOR_BCD_EN
  logic [43:0] bcd_m;
  logic bval_m;
  logic [11:0] bcd_s;
  logic bval_s;
`endif

  always #5 clk = ~clk;

  perf_monitor u_dut (
    .CLK_50(clk), .resetN(rst_n), .pc(pc), .pc_valid(pc_valid),
    .clear(clear), .ch_lo(ch_lo), .ch_hi(ch_hi), .sel(sel),
    .sel_count(cnt_m), .sel_ovf(ovf_m),
    .running(run_m), .finished(fin_m)
`ifdef PERF_MONITOR_BCD_EN
    , .sel_bcd(bcd_m), .bcd_valid(bval_m)
`endif
  );

  perf_monitor #(.COUNT_WIDTH(4)) u_sat (
    .CLK_50(clk), .resetN(rst_n), .pc(pc), .pc_valid(pc_valid),
    .clear(clear), .ch_lo(ch_lo), .ch_hi(ch_hi), .sel(sel),
    .sel_count(cnt_s), .sel_ovf(ovf_s),
    .running(run_s), .finished(fin_s)
`ifdef PERF_MONITOR_BCD_EN
    , .sel_bcd(bcd_s), .bcd_valid(bval_s)
`endif
  );

  typedef struct {
    string       tag;
    int          dut;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic rd(input int dut, input int s, input logic [31:0] e_cnt,
                    input logic e_ovf, input string tag);
    exp_t e;
    sel = SELW'(s);
    sb_q.push_back('{tag, dut, e_cnt, e_ovf});
    tick(1);
    e = sb_q.pop_front();
    chk({e.tag, "_cnt"}, (e.dut != 0) ? 64'(cnt_s) : 64'(cnt_m), 64'(e.cnt));
    chk({e.tag, "_ovf"}, (e.dut != 0) ? 64'(ovf_s) : 64'(ovf_m), 64'(e.ovf));
  endtask

  initial begin
    rst_n    = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;
    clear    = 1'b0;
    sel      = '0;
    ch_lo    = {10'd3, 10'd10, 10'd6, 10'd0};
    ch_hi    = {10'd3, 10'd5, 10'd20, 10'd9};
    tick(2);
    chk("rst_running", run_m, 0);
    chk("rst_finished", fin_m, 0);
    chk("rst_count", cnt_m, 0);
    chk("rst_ovf", ovf_m, 0);
`ifdef PERF_MONITOR_BCD_EN
    chk("rst_bcd_valid", bval_m, 0);
    chk("rst_bcd", bcd_m, 0);
`endif
    rst_n = 1'b1;
    tick(1);

    // window counting
    pc = 10'd5;
    pc_valid = 1'b1;
    tick(10);
    pc_valid = 1'b0;
    chk("t1_running", run_m, 1);
    rd(0, 0, 10, 0, "t1_total");
    rd(0, 1, 10, 0, "t1_ch0");
    rd(0, 2, 0, 0, "t1_ch1");
    rd(0, 3, 0, 0, "t1_ch2_inverted");
    rd(0, 4, 0, 0, "t1_ch3");
    rd(0, 5, 0, 0, "t1_sel_oor");

    // completion after 100 run cycles
    do_clear();
    chk("t2_idle", run_m, 0);
    pc_valid = 1'b1;
    tick(100);
    pc = FIN;
    tick(1);
    chk("t2_run_after1", run_m, 1);
    chk("t2_fin_after1", fin_m, 0);
    tick(1);
    chk("t2_finished", fin_m, 1);
    chk("t2_not_running", run_m, 0);
    pc_valid = 1'b0;
    tick(50);
    rd(0, 0, 102, 0, "t2_total");
    rd(0, 1, 100, 0, "t2_ch0");
    chk("t2_still_done", fin_m, 1);

    // hold counter resets on a non-final PC
    do_clear();
    pc_valid = 1'b1;
    pc = 10'd5;
    tick(1);
    pc = FIN;
    tick(1);
    pc = 10'd3;
    tick(1);
    pc = FIN;
    tick(1);
    chk("t3_still_run", run_m, 1);
    chk("t3_not_fin", fin_m, 0);
    tick(1);
    chk("t3_finished", fin_m, 1);
    pc_valid = 1'b0;
    rd(0, 0, 5, 0, "t3_total");
    rd(0, 1, 2, 0, "t3_ch0");
    rd(0, 4, 1, 0, "t3_ch3");

    // saturation on the 4-bit instance
    do_clear();
    pc = 10'd5;
    pc_valid = 1'b1;
    tick(20);
    pc_valid = 1'b0;
    rd(1, 1, 15, 1, "t4_sat_ch0");
    rd(1, 0, 15, 1, "t4_sat_total");
    rd(0, 1, 20, 0, "t4_wide_ch0");
    do_clear();
    chk("t4_clr_idle", run_s, 0);
    rd(1, 1, 0, 0, "t4_clr_ch0");

    // clear beats completion in the same cycle
    pc_valid = 1'b1;
    pc = 10'd5;
    tick(1);
    pc = FIN;
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    pc_valid = 1'b0;
    chk("t5_running", run_m, 0);
    chk("t5_finished", fin_m, 0);
    rd(0, 0, 0, 0, "t5_total");
    rd(0, 1, 0, 0, "t5_ch0");
    chk("t5_fin_later", fin_m, 0);

    // asynchronous reset between clock edges
    pc_valid = 1'b1;
    pc = 10'd5;
    tick(20);
    pc = FIN;
    tick(2);
    chk("t6_finished", fin_m, 1);
    pc_valid = 1'b0;
    rd(0, 1, 20, 0, "t6_ch0");
    rd(1, 1, 15, 1, "t6_sat_ch0");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_fin", fin_m, 0);
    chk("t6_async_run", run_m, 0);
    chk("t6_async_cnt", cnt_m, 0);
    chk("t6_async_sat_ovf", ovf_s, 0);
    chk("t6_async_sat_fin", fin_s, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

`ifdef PERF_MONITOR_BCD_EN
    begin
      int w;
      sel = '0;
      pc = 10'd5;
      pc_valid = 1'b1;
      tick(1232);
      pc = FIN;
      tick(2);
      pc_valid = 1'b0;
      chk("bcd_done", fin_m, 1);
      tick(3);
      w = 0;
      while (!bval_m && w < 100) begin
        tick(1);
        w++;
      end
      chk("bcd_in_time", (w < 100) ? 1 : 0, 1);
      chk("bcd_value", bcd_m, 44'h1234);
      chk("bcd_bin", cnt_m, 1234);
    end
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
